// File: rtl/ibex_pkg.sv
// ---------------------------------------------------------------------------
// ibex_pkg -- shared definitions for the sequential Zkn S-box unit.
//
// Contents:
//   zkn_sbox_state_e : FSM states (IDLE, SUB, DONE) of ibex_zkn_sbox_seq
//   ZknSboxBytes     : number of bytes in one substituted word (4)
//   gf_mul / gf_inv  : GF(2^8) arithmetic over the AES polynomial 0x11B
//   rotl8            : 8-bit rotate-left helper for the affine transforms
// ---------------------------------------------------------------------------
package ibex_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } zkn_sbox_state_e;

    localparam int unsigned ZknSboxBytes = 4;

    // Carry-less multiply reduced modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^(2+4+...+128); maps 0 to 0,
    // which is exactly the convention the AES S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [7:0] y;
        y = x;
        for (int unsigned k = 0; k < n; k++) begin
            y = {y[6:0], y[7]};
        end
        return y;
    endfunction

endpackage

// File: rtl/ibex_zkn_sbox.sv
// ---------------------------------------------------------------------------
// ibex_zkn_sbox -- combinational AES S-box, forward or inverse.
//
// Both directions share one GF(2^8) inverter:
//   forward : affine(inv(x))
//   inverse : inv(affine^-1(x))
//
// Ports:
//   i_byte : input byte
//   i_enc  : 1 = forward S-box, 0 = inverse S-box
//   o_byte : substituted byte
// ---------------------------------------------------------------------------
module ibex_zkn_sbox
    import ibex_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic       i_enc,
    output logic [7:0] o_byte
);

    logic [7:0] w_inv_affine;
    logic [7:0] w_inv_in;
    logic [7:0] w_inv_out;
    logic [7:0] w_fwd_affine;

    // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    assign w_inv_affine = rotl8(i_byte, 1) ^ rotl8(i_byte, 3) ^ rotl8(i_byte, 6) ^ 8'h05;

    assign w_inv_in  = i_enc ? i_byte : w_inv_affine;
    assign w_inv_out = gf_inv(w_inv_in);

    // Forward affine map: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    assign w_fwd_affine = w_inv_out ^ rotl8(w_inv_out, 1) ^ rotl8(w_inv_out, 2)
                        ^ rotl8(w_inv_out, 3) ^ rotl8(w_inv_out, 4) ^ 8'h63;

    assign o_byte = i_enc ? w_fwd_affine : w_inv_out;

endmodule

// File: rtl/ibex_zkn_sbox_seq.sv
// ---------------------------------------------------------------------------
// ibex_zkn_sbox_seq -- word-wide AES SubWord / InvSubWord built by
// time-sharing S-box lookups across the four bytes of a word.
//
// A request is accepted in IDLE, the word is substituted byte by byte in SUB,
// and the result is offered in DONE until the consumer takes it.
// Latency from accept (cycle N) to rsp_valid_o: N+5 with one S-box.
//
// Build option:
//   IBEX_ZKN_SBOX_SEQ_DUAL_EN : two S-box instances handle bytes idx and
//                               idx+1 each cycle, SUB lasts 2 cycles and
//                               rsp_valid_o rises at N+3.
//
// Parameters:
//   RotateOut : 1 = rsp_word_o is the result rotated left by 8 bits
//
// Ports:
//   clk_i       : clock, all state on rising edge
//   rst_ni      : asynchronous active-low reset
//   req_valid_i : request present
//   req_ready_o : request accepted when high together with req_valid_i
//   req_word_i  : four bytes to substitute
//   req_enc_i   : 1 = forward S-box, 0 = inverse S-box
//   flush_i     : abort in-flight operation (beats accept and handshake)
//   rsp_valid_o : result available
//   rsp_ready_i : consumer takes result
//   rsp_word_o  : substituted word
//   busy_o      : high in any state other than IDLE
// ---------------------------------------------------------------------------
module ibex_zkn_sbox_seq
    import ibex_pkg::*;
#(
    parameter bit RotateOut = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_word_i,
    input  logic        req_enc_i,
    input  logic        flush_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_word_o,
    output logic        busy_o
);

`ifdef IBEX_ZKN_SBOX_SEQ_DUAL_EN
    localparam int unsigned BytesPerCycle = 2;
`else
    localparam int unsigned BytesPerCycle = 1;
`endif

    localparam logic [1:0] IdxStep = 2'(BytesPerCycle);
    // Index of the first byte handled in the final SUB cycle.
    localparam logic [1:0] IdxLast = 2'(ZknSboxBytes - BytesPerCycle);

    zkn_sbox_state_e r_state;
    logic [1:0]      r_idx;
    logic [31:0]     r_word;
    logic            r_enc;
    logic [31:0]     r_result;
    logic            r_rsp_valid;
    logic            r_busy;

    logic [7:0]      w_byte0_in;
    logic [7:0]      w_byte0_out;

    assign w_byte0_in = r_word[{r_idx, 3'b000} +: 8];

    ibex_zkn_sbox u_sbox0 (
        .i_byte (w_byte0_in),
        .i_enc  (r_enc),
        .o_byte (w_byte0_out)
    );

`ifdef IBEX_ZKN_SBOX_SEQ_DUAL_EN
    logic [1:0] w_idx1;
    logic [7:0] w_byte1_in;
    logic [7:0] w_byte1_out;

    assign w_idx1     = r_idx + 2'd1;
    assign w_byte1_in = r_word[{w_idx1, 3'b000} +: 8];

    ibex_zkn_sbox u_sbox1 (
        .i_byte (w_byte1_in),
        .i_enc  (r_enc),
        .o_byte (w_byte1_out)
    );
`endif

    // Accept is only possible from IDLE and is vetoed by a flush in the same
    // cycle, so a flushed request stays pending on the requester side.
    assign req_ready_o = (r_state == IDLE) & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_word      <= 32'd0;
            r_enc       <= 1'b0;
            r_result    <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush_i) begin
            // Flush outranks both accept and the response handshake.
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_result    <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_word      <= req_word_i;
                        r_enc       <= req_enc_i;
                        r_idx       <= 2'd0;
                        r_result    <= 32'd0;
                        r_state     <= SUB;
                        r_busy      <= 1'b1;
                    end
                end
                SUB: begin
                    r_result[{r_idx, 3'b000} +: 8] <= w_byte0_out;
`ifdef IBEX_ZKN_SBOX_SEQ_DUAL_EN
                    r_result[{w_idx1, 3'b000} +: 8] <= w_byte1_out;
`endif
                    // Two-bit index wraps back to 0 after the last byte.
                    r_idx <= r_idx + IdxStep;
                    if (r_idx == IdxLast) begin
                        r_state     <= DONE;
                        r_rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // No accept here: the next request waits for IDLE.
                    if (rsp_ready_i) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_idx       <= 2'd0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign busy_o      = r_busy;

    // Key-schedule form rotates the substituted word left by one byte.
    assign rsp_word_o = RotateOut ? {r_result[23:0], r_result[31:24]} : r_result;

endmodule

// File: tb/tb_ibex_zkn_sbox_seq.sv
module tb_ibex_zkn_sbox_seq;

`ifdef IBEX_ZKN_SBOX_SEQ_DUAL_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 5;
`endif

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready, req_ready_rot;
    logic [31:0] req_word;
    logic        req_enc;
    logic        flush;
    logic        rsp_valid, rsp_valid_rot;
    logic        rsp_ready;
    logic [31:0] rsp_word, rsp_word_rot;
    logic        busy, busy_rot;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [31:0] exp_q[$];
    logic [31:0] rot_q[$];
    int          acc_q[$];

    typedef struct {
        logic [31:0] word;
        logic        enc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ibex_zkn_sbox_seq #(.RotateOut(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_word_i(req_word), .req_enc_i(req_enc), .flush_i(flush),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_word_o(rsp_word), .busy_o(busy));

    ibex_zkn_sbox_seq #(.RotateOut(1'b1)) dut_rot (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready_rot),
        .req_word_i(req_word), .req_enc_i(req_enc), .flush_i(flush),
        .rsp_valid_o(rsp_valid_rot), .rsp_ready_i(rsp_ready), .rsp_word_o(rsp_word_rot),
        .busy_o(busy_rot));

    function automatic logic [7:0] ref_fwd(input logic [7:0] b);
        int unsigned p;
        p = 2047 - 8 * int'(b);
        return SBOX_FLAT[p -: 8];
    endfunction

    function automatic logic [7:0] ref_inv(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 0; j < 256; j++) begin
            if (ref_fwd(8'(j)) == b) r = 8'(j);
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] w, input logic enc);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*8 +: 8] = enc ? ref_fwd(w[k*8 +: 8]) : ref_inv(w[k*8 +: 8]);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] w, input logic enc, input logic [31:0] exp);
        bit ok;
        ok = 0;
        req_valid = 1'b1;
        req_word  = w;
        req_enc   = enc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        check("accept", 32'(ok), 32'd1);
        if (ok) begin
            exp_q.push_back(exp);
            rot_q.push_back({exp[23:0], exp[31:24]});
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_word  = $urandom;
        req_enc   = ~enc;
    endtask

    task automatic expect_rsp(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        if (seen && exp_q.size() > 0) begin
            check({name, "_lat"}, 32'(cyc - acc_q.pop_front()), 32'(LAT));
            check({name, "_word"}, rsp_word, exp_q.pop_front());
            check({name, "_rot"}, rsp_word_rot, rot_q.pop_front());
            check({name, "_ready_in_done"}, 32'(req_ready), 32'd0);
        end
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] held;
        bit          stable;

        vecs[0] = '{32'h00010203, 1'b1, 32'h637C777B};
        vecs[1] = '{32'h637C777B, 1'b0, 32'h00010203};
        vecs[2] = '{32'h00000000, 1'b0, 32'h52525252};
        vecs[3] = '{32'hFFFFFFFF, 1'b1, 32'h16161616};
        for (int i = 4; i < 8; i++) begin
            vecs[i].word = $urandom;
            vecs[i].enc  = 1'(i & 1);
            vecs[i].exp  = ref_word(vecs[i].word, vecs[i].enc);
        end

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_word  = 32'h0;
        req_enc   = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_word", rsp_word, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);

        // Table-driven vectors through the scoreboard
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].word, vecs[i].enc, vecs[i].exp);
            expect_rsp($sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d_idle_valid", i), 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // Backpressure: response held for 10 cycles
        rsp_ready = 1'b0;
        send(32'h00010203, 1'b1, 32'h637C777B);
        expect_rsp("bp");
        held   = rsp_word;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_word !== held || req_ready || !busy) stable = 0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_released_valid", 32'(rsp_valid), 32'd0);
        check("bp_released_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Flush in second SUB cycle with a new request already pending
        send(32'hDEADBEEF, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        flush     = 1'b1;
        req_valid = 1'b1;
        req_word  = 32'h637C777B;
        req_enc   = 1'b0;
        @(negedge clk);
        check("flush_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(exp_q.pop_back());
        void'(rot_q.pop_back());
        void'(acc_q.pop_back());
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_valid", 32'(rsp_valid), 32'd0);
        check("flush_accept", 32'(req_ready), 32'd1);
        if (req_ready) begin
            exp_q.push_back(32'h00010203);
            rot_q.push_back(32'h01020300);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        expect_rsp("after_flush");

        // Reset while in DONE
        rsp_ready = 1'b0;
        send(32'h00010203, 1'b1, 32'h637C777B);
        expect_rsp("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_done_valid", 32'(rsp_valid), 32'd0);
        check("rst_done_word", rsp_word, 32'd0);
        check("rst_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_done_ready", 32'(req_ready), 32'd1);
        repeat (LAT + 1) @(negedge clk);
        check("rst_done_no_rsp", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
